// File: rtl/fir_csr_pkg.sv
// Shared constants for the FIR control/status slave: word offsets,
// STATUS bit positions and the default ID word.
package fir_csr_pkg;

  localparam logic [7:0] REG_CTRL       = 8'h00;
  localparam logic [7:0] REG_STATUS     = 8'h01;
  localparam logic [7:0] REG_SAMPLE_IN  = 8'h02;
  localparam logic [7:0] REG_SAMPLE_OUT = 8'h03;
  localparam logic [7:0] REG_ID         = 8'h04;
  localparam logic [7:0] COEF_BASE      = 8'h40;

  localparam int ST_IN_FULL   = 16;
  localparam int ST_OUT_EMPTY = 17;
  localparam int ST_UNDERFLOW = 18;
  localparam int ST_DROP      = 19;

  localparam logic [31:0] ID_DEFAULT = 32'hF1F0_0001;

  // Coefficient window is 0x40..0x7F, i.e. the top two word-address bits are 01.
  function automatic logic is_coef(input logic [7:0] word);
    return word[7:6] == COEF_BASE[7:6];
  endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with level/full/empty and a
// synchronous clear that takes priority over push and pop.
module fir_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [AW:0]      level_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (level_o == (AW+1)'(DEPTH));
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !clr_i) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/fir_avmm_csr.sv
// Avalon-MM slave for the FIR block: control/status registers, coefficient
// write forwarding, and sample FIFOs in both directions.
module fir_avmm_csr
  import fir_csr_pkg::*;
#(
  parameter int          DATA_W     = 16,
  parameter int          FIFO_DEPTH = 16,
  parameter int          NUM_TAPS   = 64,
  parameter logic [31:0] ID_VALUE   = ID_DEFAULT
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [9:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  input  logic              avs_burstcount,
  input  logic              avs_debugaccess,
  output logic [31:0]       avs_readdata,
  output logic              avs_readdatavalid,
  output logic              avs_waitrequest,
  output logic              fir_enable,
  output logic [DATA_W-1:0] smp_out_data,
  output logic              smp_out_valid,
  input  logic              smp_out_ready,
  input  logic [DATA_W-1:0] res_in_data,
  input  logic              res_in_valid,
  output logic              res_in_ready,
  output logic              coef_we,
  output logic [5:0]        coef_addr,
  output logic [DATA_W-1:0] coef_data
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]        word;
  logic [5:0]        tap;
  logic              wr_acc, rd_acc, clr;
  logic              in_push, in_pop, out_push, out_pop;
  logic              coef_hit, coef_ok;
  logic              in_full, in_empty, out_full, out_empty;
  logic [LW-1:0]     in_level, out_level;
  logic [DATA_W-1:0] in_dout, out_dout;

  logic              enable_q, underflow_q, drop_q, rvalid_q, coef_we_q;
  logic [31:0]       rdata_q, rdata_d;
  logic [5:0]        coef_addr_q;
  logic [DATA_W-1:0] coef_data_q;
  logic              unused_ok;

  assign unused_ok = ^{avs_burstcount, avs_debugaccess, avs_address[1:0],
                       avs_writedata[31:DATA_W]};

  assign word = avs_address[9:2];
  assign tap  = word[5:0];

  // Only a SAMPLE_IN write into a full in-FIFO stalls; full is the pre-cycle flag.
  assign avs_waitrequest = avs_write && (word == REG_SAMPLE_IN) && in_full;
  assign wr_acc   = avs_write && !avs_waitrequest;
  assign rd_acc   = avs_read && !avs_write;
  assign clr      = wr_acc && (word == REG_CTRL) && avs_byteenable[0] && avs_writedata[1];
  assign in_push  = wr_acc && (word == REG_SAMPLE_IN);
  assign in_pop   = smp_out_valid && smp_out_ready;
  assign out_push = res_in_valid && res_in_ready;
  assign out_pop  = rd_acc && (word == REG_SAMPLE_OUT);
  assign coef_hit = wr_acc && is_coef(word);
  assign coef_ok  = (avs_byteenable == 4'hF) && ({1'b0, tap} < 7'(NUM_TAPS));

  fir_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_in_fifo (
    .clk_i(clk_clk), .rst_ni(reset_reset_n), .clr_i(clr),
    .push_i(in_push), .din_i(avs_writedata[DATA_W-1:0]), .pop_i(in_pop),
    .dout_o(in_dout), .level_o(in_level), .full_o(in_full), .empty_o(in_empty)
  );

  fir_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_out_fifo (
    .clk_i(clk_clk), .rst_ni(reset_reset_n), .clr_i(clr),
    .push_i(out_push), .din_i(res_in_data), .pop_i(out_pop),
    .dout_o(out_dout), .level_o(out_level), .full_o(out_full), .empty_o(out_empty)
  );

  always_comb begin
    rdata_d = '0;
    case (word)
      REG_CTRL:   rdata_d[0] = enable_q;
      REG_STATUS: begin
        rdata_d[7:0]         = 8'(in_level);
        rdata_d[15:8]        = 8'(out_level);
        rdata_d[ST_IN_FULL]   = in_full;
        rdata_d[ST_OUT_EMPTY] = out_empty;
        rdata_d[ST_UNDERFLOW] = underflow_q;
        rdata_d[ST_DROP]      = drop_q;
      end
      REG_SAMPLE_OUT: if (!out_empty) rdata_d[DATA_W-1:0] = out_dout;
      REG_ID:     rdata_d = ID_VALUE;
      default:    rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      enable_q    <= 1'b0;
      underflow_q <= 1'b0;
      drop_q      <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      coef_we_q   <= 1'b0;
      coef_addr_q <= '0;
      coef_data_q <= '0;
    end else begin
      rvalid_q  <= rd_acc;
      rdata_q   <= rd_acc ? rdata_d : '0;
      coef_we_q <= coef_hit && coef_ok;
      if (coef_hit && coef_ok) begin
        coef_addr_q <= tap;
        coef_data_q <= avs_writedata[DATA_W-1:0];
      end
      if (wr_acc && (word == REG_CTRL) && avs_byteenable[0]) enable_q <= avs_writedata[0];
      if (clr) begin
        underflow_q <= 1'b0;
        drop_q      <= 1'b0;
      end else begin
        if (out_pop && out_empty)   underflow_q <= 1'b1;
        if (coef_hit && !coef_ok)   drop_q      <= 1'b1;
      end
    end
  end

  assign avs_readdata      = rdata_q;
  assign avs_readdatavalid = rvalid_q;
  assign fir_enable        = enable_q;
  assign smp_out_valid     = enable_q && !in_empty;
  assign smp_out_data      = in_empty ? '0 : in_dout;
  assign res_in_ready      = !out_full;
  assign coef_we           = coef_we_q;
  assign coef_addr         = coef_addr_q;
  assign coef_data         = coef_data_q;

endmodule

// File: tb/tb_fir_avmm_csr.sv
// Directed bench for fir_avmm_csr: queue-based reference model checked every
// cycle, plus literal expectations for each scenario.
module tb_fir_avmm_csr;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [9:0]  avs_address = '0;
  logic        avs_read = 1'b0, avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [3:0]  avs_byteenable = '0;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid, avs_waitrequest;
  logic        fir_enable, smp_out_valid, res_in_ready, coef_we;
  logic [15:0] smp_out_data, coef_data;
  logic        smp_out_ready = 1'b0;
  logic [15:0] res_in_data = '0;
  logic        res_in_valid = 1'b0;
  logic [5:0]  coef_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fir_avmm_csr dut (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
    .avs_burstcount(1'b1), .avs_debugaccess(1'b0),
    .avs_readdata(avs_readdata), .avs_readdatavalid(avs_readdatavalid),
    .avs_waitrequest(avs_waitrequest), .fir_enable(fir_enable),
    .smp_out_data(smp_out_data), .smp_out_valid(smp_out_valid),
    .smp_out_ready(smp_out_ready), .res_in_data(res_in_data),
    .res_in_valid(res_in_valid), .res_in_ready(res_in_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: register file and two queues updated at each clock edge
  logic [15:0] m_in[$];
  logic [15:0] m_out[$];
  bit          m_en, m_uf, m_drop, m_rv, m_cwe;
  logic [31:0] m_rd;
  logic [5:0]  m_caddr;
  logic [15:0] m_cdata;
  logic [7:0]  mw;
  bit          m_stall, m_wr, m_popin, m_pushres;

  function automatic logic [31:0] m_read(input logic [7:0] w);
    case (w)
      8'h00:   return {31'b0, m_en};
      8'h01:   return {12'b0, m_drop, m_uf, (m_out.size() == 0), (m_in.size() == DEPTH),
                       8'(m_out.size()), 8'(m_in.size())};
      8'h03:   return (m_out.size() > 0) ? {16'b0, m_out[0]} : 32'b0;
      8'h04:   return 32'hF1F0_0001;
      default: return 32'b0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_in.delete(); m_out.delete();
      m_en = 0; m_uf = 0; m_drop = 0; m_rv = 0; m_cwe = 0; m_rd = 0;
    end else begin
      mw        = avs_address[9:2];
      m_stall   = avs_write && mw == 8'h02 && m_in.size() == DEPTH;
      m_wr      = avs_write && !m_stall;
      m_popin   = m_en && m_in.size() > 0 && smp_out_ready;
      m_pushres = res_in_valid && m_out.size() < DEPTH;
      m_rv      = avs_read && !avs_write;
      m_rd      = m_rv ? m_read(mw) : 32'b0;
      m_cwe     = 0;
      if (m_wr && mw == 8'h00 && avs_byteenable[0] && avs_writedata[1]) begin
        m_in.delete(); m_out.delete();
        m_uf = 0; m_drop = 0;
        m_en = avs_writedata[0];
      end else begin
        if (m_popin) void'(m_in.pop_front());
        if (m_wr && mw == 8'h02) m_in.push_back(avs_writedata[15:0]);
        if (m_rv && mw == 8'h03) begin
          if (m_out.size() > 0) void'(m_out.pop_front());
          else m_uf = 1;
        end
        if (m_pushres) m_out.push_back(res_in_data);
        if (m_wr && mw == 8'h00 && avs_byteenable[0]) m_en = avs_writedata[0];
        if (m_wr && mw >= 8'h40 && mw <= 8'h7F) begin
          if (avs_byteenable == 4'hF) begin
            m_cwe = 1; m_caddr = mw[5:0]; m_cdata = avs_writedata[15:0];
          end else m_drop = 1;
        end
      end
    end
  end

  // Compare process plus collectors for the literal scenario checks
  logic [15:0] got_smp[$];
  int          coef_pulses = 0;
  logic [5:0]  last_caddr;
  logic [15:0] last_cdata;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("readdatavalid", avs_readdatavalid, m_rv);
      if (m_rv) chk("readdata", avs_readdata, m_rd);
      chk("waitrequest", avs_waitrequest,
          avs_write && avs_address[9:2] == 8'h02 && m_in.size() == DEPTH);
      chk("fir_enable", fir_enable, m_en);
      chk("smp_out_valid", smp_out_valid, m_en && m_in.size() > 0);
      if (m_en && m_in.size() > 0) chk("smp_out_data", smp_out_data, m_in[0]);
      chk("res_in_ready", res_in_ready, m_out.size() < DEPTH);
      chk("coef_we", coef_we, m_cwe);
      if (m_cwe) begin
        chk("coef_addr", coef_addr, m_caddr);
        chk("coef_data", coef_data, m_cdata);
      end
      if (smp_out_valid && smp_out_ready) got_smp.push_back(smp_out_data);
      if (coef_we) begin
        coef_pulses++;
        last_caddr = coef_addr;
        last_cdata = coef_data;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic bus_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be,
                           output int stalls);
    bit w;
    stalls = 0;
    w = 1;
    avs_address = a; avs_writedata = d; avs_byteenable = be; avs_write = 1;
    while (w && stalls <= 200) begin
      @(negedge clk);
      w = avs_waitrequest;
      tick();
      if (w) stalls++;
    end
    if (w) begin
      errors++;
      $display("FAIL write_timeout: addr 0x%03h still stalled after %0d cycles", a, stalls);
    end
    avs_write = 0; avs_byteenable = '0;
  endtask

  task automatic bus_read(input logic [9:0] a, output logic [31:0] d);
    avs_address = a; avs_read = 1;
    tick();
    avs_read = 0;
    @(negedge clk);
    chk("rvalid_latency", avs_readdatavalid, 1'b1);
    d = avs_readdata;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int st, cp0;

    #1 rst_n = 0;
    #10;
    chk("rst_readdatavalid", avs_readdatavalid, 0);
    chk("rst_readdata", avs_readdata, 0);
    chk("rst_waitrequest", avs_waitrequest, 0);
    chk("rst_res_in_ready", res_in_ready, 1);
    chk("rst_fir_enable", fir_enable, 0);
    chk("rst_smp_out_valid", smp_out_valid, 0);
    chk("rst_coef_we", coef_we, 0);
    @(negedge clk); rst_n = 1;
    tick();

    bus_read(10'h010, d); chk("id", d, 32'hF1F0_0001);
    bus_read(10'h004, d); chk("status_reset", d, 32'h0002_0000);

    // Fill the in-FIFO while paused, then stall the 17th write
    for (int i = 0; i < 16; i++) begin
      bus_write(10'h008, i, 4'hF, st);
      chk("fill_no_stall", st, 0);
    end
    bus_read(10'h004, d); chk("status_in_full", d, 32'h0003_0010);
    bus_write(10'h000, 32'h1, 4'h1, st);
    fork
      bus_write(10'h008, 32'd16, 4'hF, st);
      begin repeat (4) @(posedge clk); #2; smp_out_ready = 1; end
    join
    chk("stall_cycles", st, 5);
    for (int k = 0; k < 200 && got_smp.size() < 17; k++) tick();
    smp_out_ready = 0;
    chk("smp_count", got_smp.size(), 17);
    for (int i = 0; i < 17; i++)
      if (i < got_smp.size()) chk("smp_order", got_smp[i], i);

    // Result stream through the out-FIFO
    for (int i = 0; i < 5; i++) begin
      res_in_data = 16'(16'h0100 + i); res_in_valid = 1; tick();
    end
    res_in_valid = 0;
    bus_read(10'h004, d); chk("status_out5", d, 32'h0000_0500);
    for (int i = 0; i < 5; i++) begin
      bus_read(10'h00C, d); chk("sample_out", d, 32'h100 + i);
    end
    bus_read(10'h00C, d); chk("sample_out_empty", d, 0);
    bus_read(10'h004, d); chk("status_underflow", d, 32'h0006_0000);

    // Coefficient forwarding: full write then partial write
    cp0 = coef_pulses;
    bus_write(10'h10C, 32'h0000_1234, 4'hF, st);
    tick(); tick();
    chk("coef_pulse_count", coef_pulses - cp0, 1);
    chk("coef_tap3_addr", last_caddr, 3);
    chk("coef_tap3_data", last_cdata, 16'h1234);
    bus_write(10'h10C, 32'h0000_5678, 4'h3, st);
    tick(); tick();
    chk("coef_partial_dropped", coef_pulses - cp0, 1);
    bus_read(10'h004, d); chk("status_drop", d, 32'h000E_0000);

    // Clear flushes both FIFOs and sticky flags
    for (int i = 0; i < 4; i++) bus_write(10'h008, 32'hA0 + i, 4'hF, st);
    for (int i = 0; i < 2; i++) begin
      res_in_data = 16'(16'h0200 + i); res_in_valid = 1; tick();
    end
    res_in_valid = 0;
    bus_read(10'h004, d); chk("status_before_clr", d, 32'h000C_0204);
    bus_write(10'h000, 32'h3, 4'h1, st);
    bus_read(10'h004, d); chk("status_after_clr", d, 32'h0002_0000);
    bus_read(10'h000, d); chk("ctrl_after_clr", d, 32'h1);

    // Simultaneous read and write: write wins, no read response
    avs_address = 10'h000; avs_writedata = 32'h0; avs_byteenable = 4'h1;
    avs_write = 1; avs_read = 1;
    tick();
    avs_write = 0; avs_read = 0; avs_byteenable = '0;
    @(negedge clk); chk("rw_no_rvalid", avs_readdatavalid, 0);
    tick();
    bus_read(10'h000, d); chk("ctrl_rw_written", d, 32'h0);

    // Reset in the cycle after a read is accepted
    bus_write(10'h000, 32'h1, 4'h1, st);
    avs_address = 10'h010; avs_read = 1;
    tick();
    avs_read = 0;
    rst_n = 0;
    #1;
    chk("midrst_rvalid", avs_readdatavalid, 0);
    chk("midrst_readdata", avs_readdata, 0);
    chk("midrst_fir_enable", fir_enable, 0);
    chk("midrst_res_in_ready", res_in_ready, 1);
    repeat (2) @(posedge clk);
    #1 chk("midrst_rvalid_held", avs_readdatavalid, 0);
    @(negedge clk); rst_n = 1;
    tick();
    bus_read(10'h004, d); chk("status_after_rst", d, 32'h0002_0000);
    bus_read(10'h000, d); chk("ctrl_after_rst", d, 32'h0);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_avmm_csr.md
Name: fir_avmm_csr

Overview:
- Avalon-MM slave directly downstream of the Nios system's exported mm_bridge_0 master port; consumes its read/write transactions.
- Provides control/status registers and coefficient write forwarding for the FIR datapath.
- Buffers samples in two FIFOs: CPU -> FIR (input stream) and FIR -> CPU (result stream).

Parameters:
- DATA_W, 16, sample width in both directions.
- FIFO_DEPTH, 16, entries per FIFO; power of two, at least 4.
- NUM_TAPS, 64, coefficient slots; at most 64.
- ID_VALUE, 32'hF1F0_0001, constant returned by the ID register.

Ports:
- clk_clk  in  1  system clock (driven from clock_bridge_0_out_clk_clk).
- reset_reset_n  in  1  asynchronous active-low reset.
- avs_address  in  10  byte address; bits[1:0] ignored.
- avs_read  in  1  read request.
- avs_write  in  1  write request.
- avs_writedata  in  32  write data.
- avs_byteenable  in  4  byte enables.
- avs_burstcount  in  1  always 1; ignored.
- avs_debugaccess  in  1  ignored.
- avs_readdata  out  32  read data.
- avs_readdatavalid  out  1  read data strobe.
- avs_waitrequest  out  1  stall.
- fir_enable  out  1  CTRL.bit0.
- smp_out_data  out  DATA_W  sample to FIR.
- smp_out_valid  out  1  sample valid.
- smp_out_ready  in  1  FIR accepts the sample.
- res_in_data  in  DATA_W  FIR result.
- res_in_valid  in  1  result valid.
- res_in_ready  out  1  not output-FIFO-full.
- coef_we  out  1  one-cycle coefficient write strobe.
- coef_addr  out  6  tap index.
- coef_data  out  DATA_W  coefficient value.

Behaviour:
- Clock and reset: one clock, clk_clk. reset_reset_n is asynchronous, active-low.
- Reset values:
  - All outputs 0, except avs_waitrequest = 0 and res_in_ready = 1.
  - Both FIFOs empty; CTRL = 0; sticky flags cleared.
- Register map (word offset = address[9:2]):
  - 0x00 CTRL RW: bit0 enable. bit1 clear, write-1 self-clearing: flushes both FIFOs and clears sticky flags in the same cycle; reads back 0. Honours byteenable[0].
  - 0x01 STATUS RO: [7:0] in-FIFO level; [15:8] out-FIFO level; bit16 in_full; bit17 out_empty; bit18 underflow (sticky); bit19 drop (sticky).
  - 0x02 SAMPLE_IN WO: writedata[DATA_W-1:0] pushed into the in-FIFO.
  - 0x03 SAMPLE_OUT RO: pops the out-FIFO; zero-extended.
  - 0x04 ID RO: ID_VALUE.
  - 0x40..0x7F COEF WO: word index minus 0x40 gives the tap.
  - All other offsets: reads return 0, writes are ignored.
- Read latency: fixed 1 cycle. A read accepted in cycle N raises avs_readdatavalid for exactly cycle N+1, with readdata valid in that cycle. Back-to-back reads are pipelined, one per cycle.
- waitrequest:
  - Asserted combinationally only for a write to SAMPLE_IN while the in-FIFO is full.
  - Held until space frees; the push occurs in the first cycle waitrequest is low.
  - All other accesses complete without waitrequest.
- SAMPLE_OUT read when the out-FIFO is empty: returns 0, sets underflow; FIFO unchanged.
- COEF write:
  - Requires byteenable = 4'hF; partial writes are dropped and set the drop flag.
  - Tap index >= NUM_TAPS: dropped, sets the drop flag.
  - Otherwise, one cycle after acceptance: coef_we = 1 for one cycle, with coef_addr and coef_data registered.
- In-FIFO stream:
  - smp_out_valid = fir_enable AND in-FIFO not empty.
  - A pop occurs when smp_out_valid && smp_out_ready; smp_out_data is the FIFO head (first-word fall-through).
- Out-FIFO stream: push when res_in_valid && res_in_ready, independent of fir_enable.
- Simultaneous push and pop:
  - On a full FIFO, the pop frees space, but waitrequest still evaluates the pre-cycle full flag (conservative).
  - On an empty FIFO, the pop is invalid; the push only.
- Levels are DATA width $clog2(FIFO_DEPTH)+1; wrap via pointer extra bit.
- Clear during a stalled SAMPLE_IN write: the FIFO empties, waitrequest drops next cycle, then the write completes.
- read and write asserted together: write takes precedence; no readdatavalid is generated.
- Reset mid-transaction: a pending readdatavalid is cancelled and the FIFOs are emptied.

Decomposition:
- Package fir_csr_pkg: register offsets, COEF base 0x40, STATUS bit positions, ID_VALUE default.
- Sub-module fir_sync_fifo: parameterised WIDTH/DEPTH; first-word fall-through; provides level, full, empty, and a synchronous clear input. Instantiated twice.

Test Plan:
- Reset, then read ID at 0x010 -> readdatavalid exactly 1 cycle later, data 0xF1F00001; STATUS reads 0x00020000.
- FIR paused (fir_enable = 0): write 17 samples -> the 17th write holds waitrequest. Setting enable with smp_out_ready = 1 -> stall releases after the first pop; samples leave in order 0..16.
- FIR feeds res_in 5 values 0x0100..0x0104 -> STATUS[15:8] = 5. Five SAMPLE_OUT reads return them in order. A sixth read returns 0 and STATUS.bit18 = 1.
- Write 0x1234 to byte address 0x10C (tap 3) with byteenable F -> coef_we pulse 1 cycle, addr 3, data 0x1234. Same write with byteenable 0x3 -> no coef_we, drop flag set.
- In-FIFO holding 4 samples, out-FIFO holding 2: write CTRL = 0x3 -> both levels 0, flags cleared, CTRL reads 0x1.
- Assert reset_reset_n low in the cycle after a read is accepted -> no readdatavalid; outputs at reset values immediately (asynchronous).
